// File: rtl/mem_arbiter.sv
// Arbitrates icache and dcache word requests onto one RAM port; dcache has priority,
// with a burst limit that lets a waiting icache in. Sticky flag records any RAM error.
module mem_arbiter #(
  parameter int WORD_W    = 32,
  parameter int MAX_BURST = 2,
  parameter int CNT_W     = 2
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              ram_error
);

  typedef enum logic [1:0] {IDLE, DSERVE, ISERVE} state_t;

  localparam logic [1:0]       RAM_ACCESS = 2'b10;
  localparam logic [1:0]       RAM_ERROR  = 2'b11;
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             acc, dreq, burst_end;

  assign acc       = (ramstate == RAM_ACCESS);
  assign dreq      = dREN | dWEN;
  assign burst_end = (cnt == BURST_LAST);

  // Read data is a plain pass-through; qualified by the requester's wait going low.
  assign iload = ramload;
  assign dload = ramload;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      cnt       <= '0;
      ram_error <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (ramstate == RAM_ERROR)
        ram_error <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    iwait     = 1'b1;
    dwait     = 1'b1;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = '0;
    ramstore  = '0;
    unique case (state)
      IDLE: begin
        if (dreq) begin
          state_nxt = DSERVE;
          cnt_nxt   = '0;
        end else if (iREN) begin
          state_nxt = ISERVE;
        end
      end
      DSERVE: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        dwait    = ~acc;
        if (!dreq) begin
          state_nxt = IDLE;
        end else if (acc) begin
          if (burst_end) begin
            cnt_nxt = '0;
            // Burst limit reached: hand one word to a waiting icache.
            if (iREN)
              state_nxt = ISERVE;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      ISERVE: begin
        ramaddr = iaddr;
        ramREN  = iREN;
        iwait   = ~acc;
        if (!iREN) begin
          state_nxt = IDLE;
        end else if (acc) begin
          if (dreq) begin
            state_nxt = DSERVE;
            cnt_nxt   = '0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
